// File: rtl/branch_resolve_unit_pkg.sv
// Shared LC-3b types plus the branch resolve unit's queue entry and FSM state.
//   lc3b_word     : 16-bit machine word
//   pred_entry_t  : one recorded fetch-stage prediction
//   brs_state_t   : resolve unit control state
package lc3b_types;

  typedef logic [15:0] lc3b_word;

  typedef struct packed {
    logic       taken;
    lc3b_word   target;
    logic [7:0] history;
    logic [7:0] pc;
  } pred_entry_t;

  typedef enum logic {
    IDLE  = 1'b0,
    FLUSH = 1'b1
  } brs_state_t;

endpackage

// File: rtl/branch_resolve_unit_if.sv
// Fetch-prediction, EX/MEM-resolution and predictor-update signals of the
// branch resolve unit, bundled so the unit and its environment share one view.
//   master : environment side (drives predictions and resolutions)
//   slave  : branch_resolve_unit side (drives redirect/flush/update/stats)
interface branch_resolve_unit_if #(
  parameter int CNT_W = 16
);
  import lc3b_types::*;

  logic             stall;
  logic             pred_valid;
  logic             pred_taken;
  lc3b_word         pred_target;
  logic [7:0]       pred_history;
  logic [7:0]       fetch_pc;
  logic             resolve_valid;
  logic             resolve_is_pred;
  logic             actual_taken;
  lc3b_word         actual_target;
  lc3b_word         fallthrough_pc;

  logic             redirect;
  lc3b_word         redirect_pc;
  logic             flush;
  logic             upd_valid;
  logic             upd_taken;
  logic [7:0]       upd_pc;
  logic [7:0]       upd_history;
  lc3b_word         upd_target;
  logic [CNT_W-1:0] branch_count;
  logic [CNT_W-1:0] mispredict_count;
  logic             overflow;

  modport master (
    output stall, pred_valid, pred_taken, pred_target, pred_history, fetch_pc,
           resolve_valid, resolve_is_pred, actual_taken, actual_target, fallthrough_pc,
    input  redirect, redirect_pc, flush, upd_valid, upd_taken, upd_pc, upd_history,
           upd_target, branch_count, mispredict_count, overflow
  );

  modport slave (
    input  stall, pred_valid, pred_taken, pred_target, pred_history, fetch_pc,
           resolve_valid, resolve_is_pred, actual_taken, actual_target, fallthrough_pc,
    output redirect, redirect_pc, flush, upd_valid, upd_taken, upd_pc, upd_history,
           upd_target, branch_count, mispredict_count, overflow
  );

endinterface

// File: rtl/branch_resolve_unit_pred_queue.sv
// In-flight prediction FIFO.
//   clk, rst_n  : clock, async active-low reset
//   push/pop    : enqueue push_data / dequeue head (pop on empty is ignored)
//   clear       : drop all entries; takes priority over push and pop
//   head        : oldest entry (only meaningful when !empty)
//   full, empty : occupancy flags
//   overflow    : sticky, set when a push is dropped because the queue is full
module pred_queue
  import lc3b_types::*;
#(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        push,
  input  logic        pop,
  input  logic        clear,
  input  pred_entry_t push_data,
  output pred_entry_t head,
  output logic        full,
  output logic        empty,
  output logic        overflow
);

  localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int OCC_W  = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
  localparam logic [OCC_W-1:0] FULL_OCC = OCC_W'(DEPTH);

  pred_entry_t      mem [DEPTH];
  logic [PTR_W-1:0] head_ptr;
  logic [PTR_W-1:0] tail_ptr;
  logic [OCC_W-1:0] occ;
  logic             do_push;
  logic             do_pop;

  // Explicit wrap so non-power-of-two depths stay modulo DEPTH.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  assign full    = (occ == FULL_OCC);
  assign empty   = (occ == '0);
  assign do_pop  = pop && !empty;
  // A pop in the same cycle frees the slot, so a full queue still accepts.
  assign do_push = push && (!full || do_pop);
  assign head    = mem[head_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_ptr <= '0;
      tail_ptr <= '0;
      occ      <= '0;
      overflow <= 1'b0;
    end else if (clear) begin
      head_ptr <= '0;
      tail_ptr <= '0;
      occ      <= '0;
    end else begin
      if (do_push) tail_ptr <= ptr_inc(tail_ptr);
      if (do_pop)  head_ptr <= ptr_inc(head_ptr);
      if (do_push && !do_pop)      occ <= occ + 1'b1;
      else if (do_pop && !do_push) occ <= occ - 1'b1;
      if (push && !do_push) overflow <= 1'b1;
    end
  end

  // Entry storage needs no reset: it is only read while occupied.
  always_ff @(posedge clk) begin
    if (do_push && !clear) mem[tail_ptr] <= push_data;
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// Branch resolve unit: records fetch predictions, checks each resolving
// control instruction against its prediction, redirects/flushes on a
// mispredict, returns a predictor update per resolution and keeps stats.
//   clk, rst_n : clock, async active-low reset
//   bus        : branch_resolve_unit_if.slave (prediction, resolution,
//                redirect/flush, update packet, counters, overflow)
//
//   state | meaning
//   ------+------------------------------------------------------------
//   IDLE  | normal operation; pushes and resolutions accepted
//   FLUSH | wrong-path squash; flush high, down-counter runs to 1
module branch_resolve_unit
  import lc3b_types::*;
#(
  parameter int DEPTH        = 4,
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 16
) (
  input logic                 clk,
  input logic                 rst_n,
  branch_resolve_unit_if.slave bus
);

  localparam int FC_W = $clog2(FLUSH_CYCLES + 1);

  brs_state_t       state_q, state_d;
  logic [FC_W-1:0]  fcnt_q, fcnt_d;

  pred_entry_t      push_entry;
  pred_entry_t      head_entry;
  pred_entry_t      cmp_entry;
  logic             q_full;
  logic             q_empty;
  logic             q_overflow;

  logic             idle;
  logic             accept;
  logic             use_head;
  logic             mispredict;
  logic             push_req;
  logic             pop_req;

  logic             redirect_q;
  lc3b_word         redirect_pc_q;
  logic             upd_valid_q;
  logic             upd_taken_q;
  logic [7:0]       upd_pc_q;
  logic [7:0]       upd_history_q;
  lc3b_word         upd_target_q;
  logic [CNT_W-1:0] branch_count_q;
  logic [CNT_W-1:0] mispredict_count_q;

  assign idle     = (state_q == IDLE);
  assign accept   = bus.resolve_valid && !bus.stall && idle;
  // A predicted instruction with nothing queued is handled as non-predicted.
  assign use_head = bus.resolve_is_pred && !q_empty;
  assign cmp_entry = use_head ? head_entry : '0;

  assign mispredict = accept &&
                      ((cmp_entry.taken != bus.actual_taken) ||
                       (cmp_entry.taken && bus.actual_taken &&
                        (cmp_entry.target != bus.actual_target)));

  assign pop_req  = accept && use_head;
  assign push_req = bus.pred_valid && !bus.stall && idle;

  assign push_entry = '{taken:   bus.pred_taken,
                        target:  bus.pred_target,
                        history: bus.pred_history,
                        pc:      bus.fetch_pc};

  // A mispredict clears everything younger, including a same-cycle push.
  pred_queue #(.DEPTH(DEPTH)) u_queue (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push_req),
    .pop       (pop_req),
    .clear     (mispredict),
    .push_data (push_entry),
    .head      (head_entry),
    .full      (q_full),
    .empty     (q_empty),
    .overflow  (q_overflow)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      fcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      fcnt_q  <= fcnt_d;
    end
  end

  // The countdown ignores stall so a stalled pipeline still leaves FLUSH.
  always_comb begin
    state_d = state_q;
    fcnt_d  = fcnt_q;
    case (state_q)
      IDLE: begin
        if (mispredict) begin
          state_d = FLUSH;
          fcnt_d  = FC_W'(FLUSH_CYCLES);
        end
      end
      FLUSH: begin
        if (fcnt_q <= FC_W'(1)) begin
          state_d = IDLE;
          fcnt_d  = '0;
        end else begin
          fcnt_d = fcnt_q - 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        fcnt_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      redirect_q         <= 1'b0;
      redirect_pc_q      <= '0;
      upd_valid_q        <= 1'b0;
      upd_taken_q        <= 1'b0;
      upd_pc_q           <= '0;
      upd_history_q      <= '0;
      upd_target_q       <= '0;
      branch_count_q     <= '0;
      mispredict_count_q <= '0;
    end else begin
      redirect_q  <= mispredict;
      upd_valid_q <= accept;
      if (accept) begin
        upd_taken_q   <= bus.actual_taken;
        upd_pc_q      <= cmp_entry.pc;
        upd_history_q <= cmp_entry.history;
        upd_target_q  <= bus.actual_target;
        if (branch_count_q != '1) branch_count_q <= branch_count_q + 1'b1;
      end
      if (mispredict) begin
        redirect_pc_q <= bus.actual_taken ? bus.actual_target : bus.fallthrough_pc;
        if (mispredict_count_q != '1) mispredict_count_q <= mispredict_count_q + 1'b1;
      end
    end
  end

  assign bus.redirect         = redirect_q;
  assign bus.redirect_pc      = redirect_pc_q;
  assign bus.flush            = (state_q == FLUSH);
  assign bus.upd_valid        = upd_valid_q;
  assign bus.upd_taken        = upd_taken_q;
  assign bus.upd_pc           = upd_pc_q;
  assign bus.upd_history      = upd_history_q;
  assign bus.upd_target       = upd_target_q;
  assign bus.branch_count     = branch_count_q;
  assign bus.mispredict_count = mispredict_count_q;
  assign bus.overflow         = q_overflow;

endmodule

// File: tb/tb_branch_resolve_unit.sv
module tb_branch_resolve_unit;
  import lc3b_types::*;

  localparam int DEPTH        = 4;
  localparam int FLUSH_CYCLES = 2;
  localparam int CNT_W        = 16;
  localparam int MAXC         = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  branch_resolve_unit_if #(.CNT_W(CNT_W)) bus();

  branch_resolve_unit #(
    .DEPTH(DEPTH), .FLUSH_CYCLES(FLUSH_CYCLES), .CNT_W(CNT_W)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: queue of predictions, flush cycles remaining, counters.
  typedef struct {
    bit        taken;
    bit [15:0] target;
    bit [7:0]  history;
    bit [7:0]  pc;
  } ent_t;

  ent_t      mq[$];
  int        m_rem;
  int        m_bc, m_mc;
  bit        m_ovf, m_redirect, m_upd_valid, m_upd_taken;
  bit [15:0] m_redirect_pc, m_upd_target;
  bit [7:0]  m_upd_pc, m_upd_history;

  task automatic model_reset();
    mq.delete();
    m_rem = 0; m_bc = 0; m_mc = 0;
    m_ovf = 0; m_redirect = 0; m_upd_valid = 0; m_upd_taken = 0;
    m_redirect_pc = 0; m_upd_target = 0; m_upd_pc = 0; m_upd_history = 0;
  endtask

  task automatic model_step();
    ent_t e;
    ent_t ne;
    bit   idle, acc, pop, mis;
    m_redirect  = 0;
    m_upd_valid = 0;
    idle = (m_rem == 0);
    acc  = idle && bus.resolve_valid && !bus.stall;
    pop  = acc && bus.resolve_is_pred && (mq.size() > 0);
    e.taken = 0; e.target = 0; e.history = 0; e.pc = 0;
    if (pop) e = mq[0];
    mis = acc && ((e.taken != bus.actual_taken) ||
                  (e.taken && bus.actual_taken && e.target != bus.actual_target));
    if (m_rem > 0) m_rem--;
    if (acc) begin
      m_upd_valid   = 1;
      m_upd_taken   = bus.actual_taken;
      m_upd_pc      = e.pc;
      m_upd_history = e.history;
      m_upd_target  = bus.actual_target;
      if (m_bc < MAXC) m_bc++;
    end
    if (mis) begin
      m_redirect    = 1;
      m_redirect_pc = bus.actual_taken ? bus.actual_target : bus.fallthrough_pc;
      if (m_mc < MAXC) m_mc++;
      m_rem = FLUSH_CYCLES;
      mq.delete();
    end else begin
      if (pop) void'(mq.pop_front());
      if (idle && bus.pred_valid && !bus.stall) begin
        if (mq.size() < DEPTH) begin
          ne.taken = bus.pred_taken; ne.target = bus.pred_target;
          ne.history = bus.pred_history; ne.pc = bus.fetch_pc;
          mq.push_back(ne);
        end else begin
          m_ovf = 1;
        end
      end
    end
  endtask

  task automatic set_in(input bit pv, input bit pt, input bit [15:0] ptgt,
                        input bit [7:0] ph, input bit [7:0] fpc,
                        input bit rv, input bit rip, input bit at,
                        input bit [15:0] atgt, input bit [15:0] fall, input bit st);
    bus.pred_valid = pv; bus.pred_taken = pt; bus.pred_target = ptgt;
    bus.pred_history = ph; bus.fetch_pc = fpc;
    bus.resolve_valid = rv; bus.resolve_is_pred = rip; bus.actual_taken = at;
    bus.actual_target = atgt; bus.fallthrough_pc = fall; bus.stall = st;
  endtask

  task automatic idle_in();
    set_in(0, 0, 16'h0, 8'h0, 8'h0, 0, 0, 0, 16'h0, 16'h0, 0);
  endtask

  // Apply current inputs for one clock; outputs sampled 1 time unit after the edge.
  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    idle_in();
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({bus.redirect, bus.flush, bus.upd_valid, bus.upd_taken, bus.overflow} !== 5'b0) begin
      errors++;
      $display("FAIL reset_flags got %b want 00000",
               {bus.redirect, bus.flush, bus.upd_valid, bus.upd_taken, bus.overflow});
    end
    checks++;
    if ({bus.redirect_pc, bus.upd_pc, bus.upd_history, bus.upd_target} !== 48'h0) begin
      errors++;
      $display("FAIL reset_fields got %h want 0",
               {bus.redirect_pc, bus.upd_pc, bus.upd_history, bus.upd_target});
    end
    checks++;
    if ({bus.branch_count, bus.mispredict_count} !== 32'h0) begin
      errors++;
      $display("FAIL reset_counts got %h/%h want 0/0", bus.branch_count, bus.mispredict_count);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_correct_taken();
    set_in(1, 1, 16'h0040, 8'h05, 8'h10, 0, 0, 0, 16'h0, 16'h0, 0);
    cycle();
    set_in(0, 0, 16'h0, 8'h0, 8'h0, 1, 1, 1, 16'h0040, 16'h0012, 0);
    cycle();
    checks++;
    if (bus.upd_valid !== 1'b1 || bus.upd_history !== 8'h05 || bus.upd_pc !== 8'h10 ||
        bus.upd_taken !== 1'b1 || bus.upd_target !== 16'h0040) begin
      errors++;
      $display("FAIL correct_upd got v=%b h=%h pc=%h t=%b tgt=%h want 1 05 10 1 0040",
               bus.upd_valid, bus.upd_history, bus.upd_pc, bus.upd_taken, bus.upd_target);
    end
    checks++;
    if (bus.redirect !== 1'b0 || bus.flush !== 1'b0 || bus.branch_count !== 16'd1) begin
      errors++;
      $display("FAIL correct_noredir got redir=%b flush=%b bc=%0d want 0 0 1",
               bus.redirect, bus.flush, bus.branch_count);
    end
    idle_in();
    cycle();
    checks++;
    if (bus.upd_valid !== 1'b0) begin
      errors++;
      $display("FAIL upd_pulse got %b want 0", bus.upd_valid);
    end
  endtask

  task automatic test_dir_mispredict();
    set_in(1, 0, 16'h0100, 8'h0A, 8'h11, 0, 0, 0, 16'h0, 16'h0, 0);
    cycle();
    set_in(0, 0, 16'h0, 8'h0, 8'h0, 1, 1, 1, 16'h0120, 16'h0016, 0);
    cycle();
    checks++;
    if (bus.redirect !== 1'b1 || bus.redirect_pc !== 16'h0120 || bus.flush !== 1'b1 ||
        bus.mispredict_count !== 16'd1) begin
      errors++;
      $display("FAIL dir_mis got redir=%b pc=%h flush=%b mc=%0d want 1 0120 1 1",
               bus.redirect, bus.redirect_pc, bus.flush, bus.mispredict_count);
    end
    // Wrong-path push during flush must not reach the queue.
    set_in(1, 1, 16'h0777, 8'h33, 8'h77, 0, 0, 0, 16'h0, 16'h0, 0);
    cycle();
    checks++;
    if (bus.flush !== 1'b1 || bus.redirect !== 1'b0) begin
      errors++;
      $display("FAIL dir_flush2 got flush=%b redir=%b want 1 0", bus.flush, bus.redirect);
    end
    idle_in();
    cycle();
    checks++;
    if (bus.flush !== 1'b0) begin
      errors++;
      $display("FAIL dir_flush_end got %b want 0", bus.flush);
    end
    set_in(0, 0, 16'h0, 8'h0, 8'h0, 1, 1, 0, 16'h0, 16'h0030, 0);
    cycle();
    checks++;
    if (bus.upd_valid !== 1'b1 || bus.upd_pc !== 8'h00 || bus.redirect !== 1'b0 ||
        bus.branch_count !== 16'd3) begin
      errors++;
      $display("FAIL dir_q_empty got v=%b pc=%h redir=%b bc=%0d want 1 00 0 3",
               bus.upd_valid, bus.upd_pc, bus.redirect, bus.branch_count);
    end
    idle_in();
    cycle();
  endtask

  task automatic test_target_mispredict();
    set_in(1, 1, 16'h0040, 8'h07, 8'h12, 0, 0, 0, 16'h0, 16'h0, 0);
    cycle();
    set_in(0, 0, 16'h0, 8'h0, 8'h0, 1, 1, 1, 16'h0044, 16'h0014, 0);
    cycle();
    checks++;
    if (bus.redirect !== 1'b1 || bus.redirect_pc !== 16'h0044 || bus.mispredict_count !== 16'd2) begin
      errors++;
      $display("FAIL tgt_mis got redir=%b pc=%h mc=%0d want 1 0044 2",
               bus.redirect, bus.redirect_pc, bus.mispredict_count);
    end
    set_in(0, 0, 16'h0, 8'h0, 8'h0, 1, 0, 1, 16'h0300, 16'h0050, 0);
    cycle();
    checks++;
    if (bus.upd_valid !== 1'b0 || bus.branch_count !== 16'd4 || bus.mispredict_count !== 16'd2 ||
        bus.redirect_pc !== 16'h0044) begin
      errors++;
      $display("FAIL flush_ignore got v=%b bc=%0d mc=%0d pc=%h want 0 4 2 0044",
               bus.upd_valid, bus.branch_count, bus.mispredict_count, bus.redirect_pc);
    end
    idle_in();
    cycle();
  endtask

  task automatic test_queue_full();
    bit [7:0] exp_pc[5];
    exp_pc[0] = 8'h22; exp_pc[1] = 8'h23; exp_pc[2] = 8'h24; exp_pc[3] = 8'h26; exp_pc[4] = 8'h00;
    for (int i = 0; i < 5; i++) begin
      set_in(1, 0, 16'h0, 8'(8'h21 + i), 8'(8'h21 + i), 0, 0, 0, 16'h0, 16'h0, 0);
      cycle();
      checks++;
      if (bus.overflow !== (i == 4)) begin
        errors++;
        $display("FAIL overflow_push%0d got %b want %b", i, bus.overflow, (i == 4));
      end
    end
    // Full queue: push and pop together.
    set_in(1, 0, 16'h0, 8'h26, 8'h26, 1, 1, 0, 16'h0, 16'h0100, 0);
    cycle();
    checks++;
    if (bus.upd_pc !== 8'h21 || bus.overflow !== 1'b1 || bus.redirect !== 1'b0) begin
      errors++;
      $display("FAIL full_pushpop got pc=%h ovf=%b redir=%b want 21 1 0",
               bus.upd_pc, bus.overflow, bus.redirect);
    end
    for (int i = 0; i < 5; i++) begin
      set_in(0, 0, 16'h0, 8'h0, 8'h0, 1, 1, 0, 16'h0, 16'h0100, 0);
      cycle();
      checks++;
      if (bus.upd_valid !== 1'b1 || bus.upd_pc !== exp_pc[i] || bus.redirect !== 1'b0) begin
        errors++;
        $display("FAIL fifo_order%0d got v=%b pc=%h redir=%b want 1 %h 0",
                 i, bus.upd_valid, bus.upd_pc, bus.redirect, exp_pc[i]);
      end
    end
    idle_in();
    cycle();
  endtask

  task automatic test_nonpred();
    set_in(0, 0, 16'h0, 8'h0, 8'h0, 1, 0, 1, 16'h0200, 16'h0060, 0);
    cycle();
    checks++;
    if (bus.redirect !== 1'b1 || bus.redirect_pc !== 16'h0200 || bus.upd_history !== 8'h00 ||
        bus.upd_valid !== 1'b1 || bus.flush !== 1'b1) begin
      errors++;
      $display("FAIL nonpred got redir=%b pc=%h hist=%h v=%b flush=%b want 1 0200 00 1 1",
               bus.redirect, bus.redirect_pc, bus.upd_history, bus.upd_valid, bus.flush);
    end
    idle_in();
    cycle();
    cycle();
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      bit pv, pt, rv, rip, at, st;
      bit [15:0] ptgt, atgt, fall;
      st   = ($urandom_range(0, 9) == 0);
      pv   = ($urandom_range(0, 2) != 0);
      pt   = 1'($urandom_range(0, 1));
      ptgt = 16'(16'h0040 + 4 * $urandom_range(0, 3));
      rv   = 1'($urandom_range(0, 1));
      rip  = ($urandom_range(0, 3) != 0);
      fall = 16'($urandom_range(0, 65535));
      if (rip && mq.size() > 0 && $urandom_range(0, 3) != 0) begin
        at = mq[0].taken; atgt = mq[0].target;
      end else begin
        at = 1'($urandom_range(0, 1)); atgt = 16'(16'h0040 + 4 * $urandom_range(0, 3));
      end
      set_in(pv, pt, ptgt, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
             rv, rip, at, atgt, fall, st);
      cycle();
      checks++;
      if ({bus.redirect, bus.flush, bus.upd_valid, bus.overflow} !==
          {m_redirect, (m_rem > 0), m_upd_valid, m_ovf}) begin
        errors++;
        $display("FAIL rnd_flags[%0d] got %b want %b", i,
                 {bus.redirect, bus.flush, bus.upd_valid, bus.overflow},
                 {m_redirect, (m_rem > 0), m_upd_valid, m_ovf});
      end
      checks++;
      if ({bus.upd_taken, bus.upd_pc, bus.upd_history, bus.upd_target} !==
          {m_upd_taken, m_upd_pc, m_upd_history, m_upd_target}) begin
        errors++;
        $display("FAIL rnd_upd[%0d] got %h want %h", i,
                 {bus.upd_taken, bus.upd_pc, bus.upd_history, bus.upd_target},
                 {m_upd_taken, m_upd_pc, m_upd_history, m_upd_target});
      end
      checks++;
      if (bus.redirect_pc !== m_redirect_pc) begin
        errors++;
        $display("FAIL rnd_redirect_pc[%0d] got %h want %h", i, bus.redirect_pc, m_redirect_pc);
      end
      checks++;
      if (int'(bus.branch_count) != m_bc || int'(bus.mispredict_count) != m_mc) begin
        errors++;
        $display("FAIL rnd_counts[%0d] got %0d/%0d want %0d/%0d", i,
                 bus.branch_count, bus.mispredict_count, m_bc, m_mc);
      end
    end
    idle_in();
    repeat (FLUSH_CYCLES + 1) cycle();
  endtask

  task automatic test_reset_mid_flush();
    set_in(0, 0, 16'h0, 8'h0, 8'h0, 1, 0, 1, 16'h0300, 16'h0070, 0);
    cycle();
    idle_in();
    checks++;
    if (bus.flush !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset_flush got %b want 1", bus.flush);
    end
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    checks++;
    if (bus.flush !== 1'b0 || bus.branch_count !== 16'd0 || bus.mispredict_count !== 16'd0 ||
        bus.overflow !== 1'b0 || bus.redirect !== 1'b0) begin
      errors++;
      $display("FAIL async_reset got flush=%b bc=%0d mc=%0d ovf=%b redir=%b want 0 0 0 0 0",
               bus.flush, bus.branch_count, bus.mispredict_count, bus.overflow, bus.redirect);
    end
    #1;
    rst_n = 1'b1;
    cycle();
    checks++;
    if (bus.flush !== 1'b0 || bus.branch_count !== 16'd0 || bus.upd_valid !== 1'b0) begin
      errors++;
      $display("FAIL post_reset got flush=%b bc=%0d v=%b want 0 0 0",
               bus.flush, bus.branch_count, bus.upd_valid);
    end
  endtask

  task automatic test_saturation();
    set_in(0, 0, 16'h0, 8'h0, 8'h0, 1, 0, 0, 16'h0, 16'h0002, 0);
    repeat (MAXC - 1) cycle();
    checks++;
    if (bus.branch_count !== 16'hFFFE || bus.mispredict_count !== 16'h0) begin
      errors++;
      $display("FAIL sat_pre got bc=%h mc=%h want FFFE 0000", bus.branch_count, bus.mispredict_count);
    end
    cycle();
    checks++;
    if (bus.branch_count !== 16'hFFFF) begin
      errors++;
      $display("FAIL sat_reach got %h want FFFF", bus.branch_count);
    end
    cycle();
    checks++;
    if (bus.branch_count !== 16'hFFFF || bus.upd_valid !== 1'b1) begin
      errors++;
      $display("FAIL sat_hold got bc=%h v=%b want FFFF 1", bus.branch_count, bus.upd_valid);
    end
    idle_in();
    cycle();
  endtask

  initial begin
    test_reset();
    test_correct_taken();
    test_dir_mispredict();
    test_target_mispredict();
    test_queue_full();
    test_nonpred();
    test_random();
    test_reset_mid_flush();
    test_saturation();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
